multi_input_arbiter: RTL

- Fan-in counterpart to the codebase's single-source, multi-sink gate primitives.
- Merges N requesters onto one shared registered output channel using round-robin arbitration.
- Each requester presents a request line and a data word. The block grants one requester at a time, muxes its data to the output, and revokes the grant on release or timeout.
- Sits between multiple producer blocks and a single consumer in the Chapter 5 training designs.

---
 rtl/multi_input_arbiter_pkg.sv | 13 +
 rtl/rr_priority_pick.sv | 28 ++
 rtl/multi_input_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/multi_input_arbiter_pkg.sv
// Shared definitions for the round-robin fan-in arbiter: FSM encodings and
// the default grant hold limit.
package multi_input_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  localparam int HOLD_MAX_DEF = 4;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request bit at or above the
// pointer, wrapping modulo N_REQ.
module rr_priority_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] sel
);

  always_comb begin : pick
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/multi_input_arbiter.sv
// Round-robin arbiter merging N_REQ requesters onto one registered output
// channel, with a bounded hold time and a mandatory gap between grants.
module multi_input_arbiter
  import multi_input_arbiter_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int IDX_W    = 2,
  parameter int DW       = 8,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] din,
  output logic [N_REQ-1:0]    gnt,
  output logic [IDX_W-1:0]    gnt_idx,
  output logic                gnt_vld,
  output logic [DW-1:0]       dout,
  output logic                timeout
);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [7:0]       hold, hold_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             vld_nxt;
  logic [DW-1:0]    dout_nxt;
  logic             to_nxt;
  logic             pick_found;
  logic [IDX_W-1:0] pick_sel;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .sel   (pick_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      hold    <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      dout    <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      hold    <= hold_nxt;
      gnt     <= gnt_nxt;
      gnt_idx <= idx_nxt;
      gnt_vld <= vld_nxt;
      dout    <= dout_nxt;
      timeout <= to_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold;
    gnt_nxt   = gnt;
    idx_nxt   = gnt_idx;
    vld_nxt   = gnt_vld;
    dout_nxt  = dout;
    to_nxt    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_nxt           = '0;
          gnt_nxt[pick_sel] = 1'b1;
          idx_nxt           = pick_sel;
          vld_nxt           = 1'b1;
          hold_nxt          = 8'd1;
          dout_nxt          = din[pick_sel*DW +: DW];
          state_nxt         = ST_BUSY;
        end
      end
      ST_BUSY: begin
        dout_nxt = din[gnt_idx*DW +: DW];
        // A release wins over a simultaneous hold expiry, so timeout stays low.
        if (!req[gnt_idx] || hold == 8'(HOLD_MAX)) begin
          to_nxt    = req[gnt_idx];
          gnt_nxt   = '0;
          idx_nxt   = '0;
          vld_nxt   = 1'b0;
          hold_nxt  = '0;
          ptr_nxt   = (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
          state_nxt = ST_GAP;
        end else begin
          hold_nxt = hold + 8'd1;
        end
      end
      ST_GAP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
